blitter_bus_responder: RTL and testbench

- Memory-side responder for the blitter's ST bus-master interface.
- Arbitrates the shared 4-slot bus between the CPU and a requesting bus master.
- Once the bus is granted, it executes the master's single-word reads and writes against the RAM port, and returns read data aligned to the master's bus_cycle 0 sampling point.
- Sits between the blitter (br, bm_*) and the RAM/bus mux, alongside the CPU slot logic.

---
 rtl/blitter_bus_responder_pkg.sv | 26 ++
 rtl/blitter_bus_responder_bus_access_pipe.sv | 115 +++++++++++
 rtl/blitter_bus_responder.sv | 84 ++++++++
 tb/tb_blitter_bus_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blitter_bus_responder_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// blitter_bus_responder_pkg : shared arbiter states and bus slot constants
// Rev 1.0
// ------------------------------------------------------------------
package blitter_bus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2,
    REL   = 2'd3
  } arb_state_e;

  localparam logic [1:0]  SLOT_ADV    = 2'd0;
  localparam logic [1:0]  SLOT_STROBE = 2'd1;
  localparam logic [1:0]  SLOT_MEM    = 2'd2;
  localparam logic [1:0]  SLOT_LAST   = 2'd3;
  localparam logic [15:0] OPEN_BUS    = 16'hFFFF;

  function automatic logic [1:0] slot_after(input logic [1:0] s);
    return (s == SLOT_LAST) ? SLOT_ADV : 2'(s + 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/blitter_bus_responder_bus_access_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// bus_access_pipe : slot-1 capture, slot-2 RAM strobe, read latch, range check
// Rev 1.0
// ------------------------------------------------------------------
module bus_access_pipe
  import blitter_bus_responder_pkg::*;
#(
  parameter logic [22:0] RAM_TOP = 23'h200000,
  parameter int          ACC_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       bus_cycle,
  input  logic             bm_read,
  input  logic             bm_write,
  input  logic [22:0]      bm_addr,
  input  logic [15:0]      bm_data_out,
  input  logic [15:0]      ram_din,
  output logic [15:0]      bm_data_in,
  output logic [22:0]      ram_addr,
  output logic             ram_oe,
  output logic             ram_we,
  output logic [15:0]      ram_dout,
  output logic             range_err,
  output logic [ACC_W-1:0] acc_cnt,
  output logic             busy
);

  logic             pend_q, pend_d;
  logic             pend_rd_q, pend_rd_d;
  logic             pend_oor_q, pend_oor_d;
  logic [22:0]      ram_addr_q, ram_addr_d;
  logic [15:0]      ram_dout_q, ram_dout_d;
  logic             ram_oe_q, ram_oe_d;
  logic             ram_we_q, ram_we_d;
  logic [15:0]      bm_data_in_q, bm_data_in_d;
  logic             range_err_q, range_err_d;
  logic [ACC_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             sample;
  logic             out_of_range;

  assign sample       = enable && (bus_cycle == SLOT_STROBE);
  assign out_of_range = (bm_addr >= RAM_TOP);

  always_comb begin
    pend_d       = 1'b0;
    pend_rd_d    = pend_rd_q;
    pend_oor_d   = pend_oor_q;
    ram_oe_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_dout_d   = ram_dout_q;
    bm_data_in_d = bm_data_in_q;
    range_err_d  = range_err_q;
    acc_cnt_d    = acc_cnt_q;
    if (sample) begin
      if (bm_read && bm_write) begin
        range_err_d = 1'b1;
      end else if (bm_read || bm_write) begin
        pend_d     = 1'b1;
        pend_rd_d  = bm_read;
        pend_oor_d = out_of_range;
        ram_addr_d = bm_addr;
        ram_dout_d = bm_data_out;
        ram_oe_d   = bm_read && !out_of_range;
        ram_we_d   = bm_write && !out_of_range;
        if (out_of_range) range_err_d = 1'b1;
      end
    end
    // Out-of-range accesses still complete (and count) but return open-bus data.
    if (pend_q && (bus_cycle == SLOT_MEM)) begin
      acc_cnt_d = acc_cnt_q + ACC_W'(1);
      if (pend_rd_q) bm_data_in_d = pend_oor_q ? OPEN_BUS : ram_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= 1'b0;
      pend_rd_q    <= 1'b0;
      pend_oor_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_dout_q   <= '0;
      ram_oe_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      bm_data_in_q <= OPEN_BUS;
      range_err_q  <= 1'b0;
      acc_cnt_q    <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_rd_q    <= pend_rd_d;
      pend_oor_q   <= pend_oor_d;
      ram_addr_q   <= ram_addr_d;
      ram_dout_q   <= ram_dout_d;
      ram_oe_q     <= ram_oe_d;
      ram_we_q     <= ram_we_d;
      bm_data_in_q <= bm_data_in_d;
      range_err_q  <= range_err_d;
      acc_cnt_q    <= acc_cnt_d;
    end
  end

  assign bm_data_in = bm_data_in_q;
  assign ram_addr   = ram_addr_q;
  assign ram_oe     = ram_oe_q;
  assign ram_we     = ram_we_q;
  assign ram_dout   = ram_dout_q;
  assign range_err  = range_err_q;
  assign acc_cnt    = acc_cnt_q;
  assign busy       = pend_q;

endmodule
`default_nettype wire

// File: rtl/blitter_bus_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// blitter_bus_responder : bus arbiter + single-word access responder for the blitter
// Rev 1.0
// ------------------------------------------------------------------
module blitter_bus_responder
  import blitter_bus_responder_pkg::*;
#(
  parameter logic [22:0] RAM_TOP = 23'h200000,
  parameter int          ACC_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       bus_cycle,
  input  logic             cpu_busy,
  input  logic             br,
  output logic             bg,
  input  logic [22:0]      bm_addr,
  input  logic             bm_read,
  input  logic             bm_write,
  input  logic [15:0]      bm_data_out,
  output logic [15:0]      bm_data_in,
  output logic [22:0]      ram_addr,
  output logic             ram_oe,
  output logic             ram_we,
  output logic [15:0]      ram_dout,
  input  logic [15:0]      ram_din,
  output logic             range_err,
  output logic [ACC_W-1:0] acc_cnt
);

  arb_state_e state_q, state_d;
  logic       period_end;
  logic       pipe_busy;

  // Grant changes only as the slot counter wraps, so bg edges align to slot 0.
  assign period_end = (slot_after(bus_cycle) == SLOT_ADV);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (br) state_d = REQ;
      REQ: begin
        if (!br)                           state_d = IDLE;
        else if (period_end && !cpu_busy)  state_d = GRANT;
      end
      GRANT:   if (!br && period_end && !pipe_busy) state_d = REL;
      REL:     if (period_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign bg = (state_q == GRANT);

  bus_access_pipe #(
    .RAM_TOP (RAM_TOP),
    .ACC_W   (ACC_W)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .enable      (bg),
    .bus_cycle   (bus_cycle),
    .bm_read     (bm_read),
    .bm_write    (bm_write),
    .bm_addr     (bm_addr),
    .bm_data_out (bm_data_out),
    .ram_din     (ram_din),
    .bm_data_in  (bm_data_in),
    .ram_addr    (ram_addr),
    .ram_oe      (ram_oe),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout),
    .range_err   (range_err),
    .acc_cnt     (acc_cnt),
    .busy        (pipe_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_blitter_bus_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_blitter_bus_responder : scoreboard bench with a transaction-level reference model
// Rev 1.0
// ------------------------------------------------------------------
module tb_blitter_bus_responder;
  import blitter_bus_responder_pkg::*;

  localparam logic [22:0] RAM_TOP = 23'h200000;
  localparam int          ACC_W   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       bus_cycle = 2'd0;
  logic             cpu_busy = 1'b0;
  logic             br = 1'b0;
  logic             bg;
  logic [22:0]      bm_addr = '0;
  logic             bm_read = 1'b0;
  logic             bm_write = 1'b0;
  logic [15:0]      bm_data_out = '0;
  logic [15:0]      bm_data_in;
  logic [22:0]      ram_addr;
  logic             ram_oe;
  logic             ram_we;
  logic [15:0]      ram_dout;
  logic [15:0]      ram_din = '0;
  logic             range_err;
  logic [ACC_W-1:0] acc_cnt;

  blitter_bus_responder #(.RAM_TOP(RAM_TOP), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .bus_cycle(bus_cycle), .cpu_busy(cpu_busy),
    .br(br), .bg(bg), .bm_addr(bm_addr), .bm_read(bm_read), .bm_write(bm_write),
    .bm_data_out(bm_data_out), .bm_data_in(bm_data_in), .ram_addr(ram_addr),
    .ram_oe(ram_oe), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
    .range_err(range_err), .acc_cnt(acc_cnt)
  );

  // Slot counter advances just after each rising edge, like the real bus sequencer.
  initial begin
    forever begin
      #5 clk = 1'b1;
      #1 bus_cycle = bus_cycle + 2'd1;
      #4 clk = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic wr; logic [22:0] addr; logic [15:0] data; } op_t;
  typedef struct { logic [ACC_W-1:0] acc; logic [15:0] rdata; logic rerr; } done_t;

  op_t   exp_ops[$];
  done_t exp_done[$];
  op_t   mon_op;
  done_t mon_done;
  logic [ACC_W-1:0] last_acc = '0;

  // Reference model state: what a master would observe after each access.
  logic [ACC_W-1:0] m_acc   = '0;
  logic [15:0]      m_rdata = 16'hFFFF;
  logic             m_rerr  = 1'b0;

  always @(negedge clk) begin
    if (ram_oe || ram_we) begin
      if (exp_ops.size() == 0) begin
        check("unexpected_strobe", {30'b0, ram_we, ram_oe}, 32'h0);
      end else begin
        mon_op = exp_ops.pop_front();
        check("op_kind", {30'b0, ram_we, ram_oe}, mon_op.wr ? 32'h2 : 32'h1);
        check("op_slot", bus_cycle, SLOT_MEM);
        check("op_addr", ram_addr, mon_op.addr);
        if (mon_op.wr) check("op_wdata", ram_dout, mon_op.data);
      end
    end
    if (reset) begin
      last_acc = acc_cnt;
    end else if (acc_cnt !== last_acc) begin
      if (exp_done.size() == 0) begin
        check("unexpected_completion", acc_cnt, last_acc);
      end else begin
        mon_done = exp_done.pop_front();
        check("done_acc", acc_cnt, mon_done.acc);
        check("done_rdata", bm_data_in, mon_done.rdata);
        check("done_rerr", range_err, mon_done.rerr);
      end
      last_acc = acc_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic goto_slot(input logic [1:0] s);
    for (int i = 0; i < 4 && bus_cycle != s; i++) tick();
  endtask

  // Presents an access for the slot currently in progress; returns one slot later.
  task automatic issue(input logic rd, input logic wr, input logic [22:0] a,
                       input logic [15:0] d, input logic [15:0] din);
    logic oor;
    bm_read = rd; bm_write = wr; bm_addr = a; bm_data_out = d; ram_din = din;
    oor = (a >= RAM_TOP);
    if (bg && bus_cycle == SLOT_STROBE) begin
      if (rd && wr) begin
        m_rerr = 1'b1;
      end else if (rd || wr) begin
        if (!oor) exp_ops.push_back('{wr, a, d});
        if (oor) m_rerr = 1'b1;
        m_acc = m_acc + 1'b1;
        if (rd) m_rdata = oor ? 16'hFFFF : din;
        exp_done.push_back('{m_acc, m_rdata, m_rerr});
      end
    end
    tick();
    bm_read = 1'b0; bm_write = 1'b0;
  endtask

  task automatic stray();
    bm_read     = 1'($urandom_range(0, 1));
    bm_write    = 1'($urandom_range(0, 1));
    bm_addr     = 23'($urandom);
    bm_data_out = 16'($urandom);
  endtask

  initial begin
    int          kind;
    int          waited;
    logic [22:0] a;
    logic        rsel;

    // Reset with a request pending: reset must win.
    reset = 1'b1; br = 1'b1;
    repeat (3) tick();
    check("rst_bg", bg, 0);
    check("rst_ram_oe", ram_oe, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_dout", ram_dout, 0);
    check("rst_bm_data_in", bm_data_in, 16'hFFFF);
    check("rst_range_err", range_err, 0);
    check("rst_acc_cnt", acc_cnt, 0);

    // Grant held off while the CPU owns slot 3 for two periods.
    cpu_busy = 1'b1;
    reset = 1'b0;
    goto_slot(3); tick();
    check("grant_held_p1", bg, 0);
    goto_slot(3); tick();
    check("grant_held_p2", bg, 0);
    goto_slot(2);
    cpu_busy = 1'b0;
    tick();
    check("grant_not_before_wrap", bg, 0);
    tick();
    check("grant_rise_slot0", bg, 1);

    // Directed read.
    goto_slot(1);
    issue(1'b1, 1'b0, 23'h000100, 16'h0000, 16'hA5C3);
    check("rd_oe_slot2", ram_oe, 1);
    check("rd_addr", ram_addr, 23'h000100);
    tick();
    ram_din = 16'($urandom);
    check("rd_oe_off_slot3", ram_oe, 0);
    check("rd_data_slot3", bm_data_in, 16'hA5C3);
    check("rd_acc_cnt", acc_cnt, 1);
    tick();
    check("rd_data_hold_slot0", bm_data_in, 16'hA5C3);

    // Directed write.
    goto_slot(1);
    issue(1'b0, 1'b1, 23'h000200, 16'h1234, 16'($urandom));
    check("wr_we_slot2", ram_we, 1);
    check("wr_oe_slot2", ram_oe, 0);
    check("wr_dout", ram_dout, 16'h1234);

    // Out-of-range read at the first address past RAM.
    goto_slot(1);
    issue(1'b1, 1'b0, RAM_TOP, 16'h0000, 16'h5A5A);
    check("oor_no_oe", ram_oe, 0);
    tick();
    check("oor_open_bus", bm_data_in, 16'hFFFF);
    check("oor_range_err", range_err, 1);
    repeat (40) tick();
    check("oor_range_err_sticky", range_err, 1);

    // Randomized traffic, with strobes also waved in the slots that must ignore them.
    for (int p = 0; p < 60; p++) begin
      goto_slot(0);
      stray();
      tick();
      kind = $urandom_range(0, 9);
      a    = 23'($urandom_range(0, 32'h1FFFFF));
      rsel = 1'($urandom_range(0, 1));
      case (kind)
        0, 1, 2, 3: issue(1'b1, 1'b0, a, 16'($urandom), 16'($urandom));
        4, 5, 6:    issue(1'b0, 1'b1, a, 16'($urandom), 16'($urandom));
        7:          issue(1'b0, 1'b0, a, 16'($urandom), 16'($urandom));
        8:          issue(rsel, !rsel, RAM_TOP + a, 16'($urandom), 16'($urandom));
        default:    issue(1'b1, 1'b1, a, 16'($urandom), 16'($urandom));
      endcase
      stray();
      tick();
      ram_din = 16'($urandom);
      stray();
      tick();
    end
    bm_read = 1'b0; bm_write = 1'b0;
    check("rand_range_err", range_err, m_rerr);

    // Release: request drops while a read is being presented.
    goto_slot(1);
    br = 1'b0;
    issue(1'b1, 1'b0, 23'($urandom_range(0, 32'h1FFFFF)), 16'h0, 16'($urandom));
    tick();
    check("rel_bg_while_completing", bg, 1);
    tick();
    check("rel_bg_fall_slot0", bg, 0);
    br = 1'b1;
    tick();
    bm_read = 1'b1; bm_addr = 23'h000040;
    check("rel_bg_low_s1", bg, 0);
    tick();
    bm_read = 1'b0;
    check("rel_bg_low_s2", bg, 0);
    tick();
    check("rel_bg_low_s3", bg, 0);
    waited = 0;
    while (!bg && waited < 16) begin
      tick();
      waited++;
    end
    check("regrant_latency", waited, 5);
    check("regrant_slot", bus_cycle, SLOT_ADV);

    // Reset arriving while a write strobe is on the RAM.
    goto_slot(1);
    issue(1'b0, 1'b1, 23'h000300, 16'hBEEF, 16'h0000);
    check("rstw_we_before", ram_we, 1);
    reset = 1'b1;
    exp_done.delete();
    m_acc = '0; m_rdata = 16'hFFFF; m_rerr = 1'b0;
    tick();
    check("rstw_we_dropped", ram_we, 0);
    check("rstw_bg", bg, 0);
    check("rstw_acc_cnt", acc_cnt, 0);
    check("rstw_bm_data_in", bm_data_in, 16'hFFFF);
    check("rstw_range_err", range_err, 0);
    tick();
    reset = 1'b0;
    br = 1'b0;
    repeat (8) tick();
    check("ops_drained", exp_ops.size(), 0);
    check("done_drained", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
